// File: rtl/gshare_branch_tracker_if.sv
// Bundle of allocation, resolution, flush and training signals between the
// pipeline/predictor side (master) and the branch tracker (slave).
interface gshare_branch_tracker_if #(
   parameter int PC_BITS   = 7,
   parameter int HIST_BITS = 7,
   parameter int TAG_BITS  = 2
);
   logic                 alloc_valid;
   logic                 alloc_ready;
   logic [PC_BITS-1:0]   alloc_pc;
   logic [HIST_BITS-1:0] alloc_history;
   logic                 alloc_pred_taken;
   logic [TAG_BITS-1:0]  alloc_tag;
   logic                 resolve_valid;
   logic [TAG_BITS-1:0]  resolve_tag;
   logic                 resolve_taken;
   logic                 flush;
   logic                 train_valid;
   logic [PC_BITS-1:0]   train_pc;
   logic [HIST_BITS-1:0] train_history;
   logic                 train_taken;
   logic                 train_mispredicted;
   logic [TAG_BITS:0]    count;

   modport master (
      output alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
             resolve_valid, resolve_tag, resolve_taken, flush,
      input  alloc_ready, alloc_tag, train_valid, train_pc, train_history,
             train_taken, train_mispredicted, count
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
             resolve_valid, resolve_tag, resolve_taken, flush,
      output alloc_ready, alloc_tag, train_valid, train_pc, train_history,
             train_taken, train_mispredicted, count
   );
endinterface

// File: rtl/gshare_branch_tracker.sv
// In-order tracking queue for gshare predictions: resolves by tag out of order,
// retires in program order into the predictor's training port, squashes on mispredict.
module gshare_branch_tracker #(
   parameter int PC_BITS   = 7,
   parameter int HIST_BITS = 7,
   parameter int DEPTH     = 4,
   parameter int TAG_BITS  = 2
) (
   input logic                    clk,
   input logic                    rst,
   gshare_branch_tracker_if.slave bus
);
   localparam logic [TAG_BITS:0]   FULL_CNT = (TAG_BITS+1)'(DEPTH);
   localparam logic [TAG_BITS:0]   CNT_ONE  = (TAG_BITS+1)'(1);
   localparam logic [TAG_BITS-1:0] PTR_ONE  = TAG_BITS'(1);

   logic [DEPTH-1:0]     valid_q, valid_d, resolved_q, resolved_d;
   logic [DEPTH-1:0]     pred_q, pred_d, act_q, act_d;
   logic [PC_BITS-1:0]   pc_q [DEPTH];
   logic [PC_BITS-1:0]   pc_d [DEPTH];
   logic [HIST_BITS-1:0] hist_q [DEPTH];
   logic [HIST_BITS-1:0] hist_d [DEPTH];
   logic [TAG_BITS-1:0]  head_q, head_d, tail_q, tail_d;
   logic [TAG_BITS:0]    count_q, count_d;
   logic                 train_valid_q, train_valid_d;
   logic [PC_BITS-1:0]   train_pc_q, train_pc_d;
   logic [HIST_BITS-1:0] train_hist_q, train_hist_d;
   logic                 train_taken_q, train_taken_d;
   logic                 train_mis_q, train_mis_d;
   logic                 alloc_ready, alloc_ok, retire, mispred;

   // Readiness looks only at the registered count, so a same-cycle retire never frees a slot early.
   assign alloc_ready = (count_q != FULL_CNT);
   assign alloc_ok    = bus.alloc_valid && alloc_ready;
   assign retire      = valid_q[head_q] && resolved_q[head_q];
   assign mispred     = act_q[head_q] ^ pred_q[head_q];

   assign bus.alloc_ready        = alloc_ready;
   assign bus.alloc_tag          = tail_q;
   assign bus.count              = count_q;
   assign bus.train_valid        = train_valid_q;
   assign bus.train_pc           = train_pc_q;
   assign bus.train_history      = train_hist_q;
   assign bus.train_taken        = train_taken_q;
   assign bus.train_mispredicted = train_mis_q;

   always_comb begin
      valid_d       = valid_q;
      resolved_d    = resolved_q;
      pred_d        = pred_q;
      act_d         = act_q;
      pc_d          = pc_q;
      hist_d        = hist_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      train_valid_d = 1'b0;
      train_pc_d    = train_pc_q;
      train_hist_d  = train_hist_q;
      train_taken_d = train_taken_q;
      train_mis_d   = train_mis_q;

      if (bus.flush) begin
         valid_d    = '0;
         resolved_d = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (bus.resolve_valid && valid_q[bus.resolve_tag] && !resolved_q[bus.resolve_tag]) begin
            resolved_d[bus.resolve_tag] = 1'b1;
            act_d[bus.resolve_tag]      = bus.resolve_taken;
         end
         if (alloc_ok) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            pred_d[tail_q]     = bus.alloc_pred_taken;
            pc_d[tail_q]       = bus.alloc_pc;
            hist_d[tail_q]     = bus.alloc_history;
            tail_d             = tail_q + PTR_ONE;
         end
         case ({alloc_ok, retire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (retire) begin
            train_valid_d      = 1'b1;
            train_pc_d         = pc_q[head_q];
            train_hist_d       = hist_q[head_q];
            train_taken_d      = act_q[head_q];
            train_mis_d        = mispred;
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + PTR_ONE;
            // Wrong-path work behind a mispredict is discarded, including this cycle's allocation.
            if (mispred) begin
               valid_d    = '0;
               resolved_d = '0;
               tail_d     = head_q + PTR_ONE;
               count_d    = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= '0;
         resolved_q    <= '0;
         pred_q        <= '0;
         act_q         <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         train_valid_q <= 1'b0;
         train_pc_q    <= '0;
         train_hist_q  <= '0;
         train_taken_q <= 1'b0;
         train_mis_q   <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         resolved_q    <= resolved_d;
         pred_q        <= pred_d;
         act_q         <= act_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         train_valid_q <= train_valid_d;
         train_pc_q    <= train_pc_d;
         train_hist_q  <= train_hist_d;
         train_taken_q <= train_taken_d;
         train_mis_q   <= train_mis_d;
      end
   end

   // Payload is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      pc_q   <= pc_d;
      hist_q <= hist_d;
   end
endmodule

// File: tb/tb_gshare_branch_tracker.sv
// Directed bench: expected train pulses (with due cycle) go into a scoreboard
// queue; a negedge monitor pops and compares each pulse the tracker presents.
module tb_gshare_branch_tracker;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gshare_branch_tracker_if #(.PC_BITS(7), .HIST_BITS(7), .TAG_BITS(2)) bus ();

   gshare_branch_tracker #(.PC_BITS(7), .HIST_BITS(7), .DEPTH(4), .TAG_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int pc;
      int hist;
      int taken;
      int mis;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.train_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL train_unexpected got pc=%0d hist=%0d taken=%0d mis=%0d cyc=%0d, none expected",
                     bus.train_pc, bus.train_history, bus.train_taken, bus.train_mispredicted, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (int'(bus.train_pc) != mon_e.pc || int'(bus.train_history) != mon_e.hist ||
                int'(bus.train_taken) != mon_e.taken || int'(bus.train_mispredicted) != mon_e.mis ||
                cyc != mon_e.due) begin
               errors++;
               $display("FAIL train_pulse got pc=%0d hist=%0d taken=%0d mis=%0d cyc=%0d exp pc=%0d hist=%0d taken=%0d mis=%0d cyc=%0d",
                        bus.train_pc, bus.train_history, bus.train_taken, bus.train_mispredicted, cyc,
                        mon_e.pc, mon_e.hist, mon_e.taken, mon_e.mis, mon_e.due);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.alloc_valid      = 1'b0;
      bus.alloc_pc         = '0;
      bus.alloc_history    = '0;
      bus.alloc_pred_taken = 1'b0;
      bus.resolve_valid    = 1'b0;
      bus.resolve_tag      = '0;
      bus.resolve_taken    = 1'b0;
      bus.flush            = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic alloc(input int pc, input int hist, input int pred);
      bus.alloc_valid      = 1'b1;
      bus.alloc_pc         = 7'(pc);
      bus.alloc_history    = 7'(hist);
      bus.alloc_pred_taken = pred[0];
      step();
      bus.alloc_valid      = 1'b0;
   endtask

   task automatic resolve(input int tag, input int taken);
      bus.resolve_valid = 1'b1;
      bus.resolve_tag   = 2'(tag);
      bus.resolve_taken = taken[0];
      step();
      bus.resolve_valid = 1'b0;
   endtask

   task automatic expect_train(input int pc, input int hist, input int taken, input int mis, input int lat);
      exp_t e;
      e.pc    = pc;
      e.hist  = hist;
      e.taken = taken;
      e.mis   = mis;
      e.due   = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_count"},       int'(bus.count), 0);
      chk({tag, "_alloc_ready"}, int'(bus.alloc_ready), 1);
      chk({tag, "_alloc_tag"},   int'(bus.alloc_tag), 0);
      chk({tag, "_train_valid"}, int'(bus.train_valid), 0);
      chk({tag, "_train_pc"},    int'(bus.train_pc), 0);
      chk({tag, "_train_hist"},  int'(bus.train_history), 0);
      chk({tag, "_train_taken"}, int'(bus.train_taken), 0);
      chk({tag, "_train_mis"},   int'(bus.train_mispredicted), 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_reset_vals("rst0");

      // Single entry, mispredicted not-taken
      chk("t1_tag", int'(bus.alloc_tag), 0);
      alloc(10, 0, 0);
      chk("t1_count_alloc", int'(bus.count), 1);
      expect_train(10, 0, 1, 1, 2);
      resolve(0, 1);
      chk("t1_count_resolved", int'(bus.count), 1);
      step();
      chk("t1_count_retired", int'(bus.count), 0);
      step();
      step();

      // Out-of-order resolve, in-order drain
      do_reset();
      chk("t2_tag0", int'(bus.alloc_tag), 0);
      alloc(20, 7'h15, 0);
      chk("t2_tag1", int'(bus.alloc_tag), 1);
      alloc(14, 7'h2A, 0);
      resolve(1, 0);
      step();
      step();
      chk("t2_count_wait", int'(bus.count), 2);
      expect_train(20, 7'h15, 0, 0, 2);
      expect_train(14, 7'h2A, 0, 0, 3);
      resolve(0, 0);
      step();
      chk("t2_count_one", int'(bus.count), 1);
      step();
      chk("t2_count_zero", int'(bus.count), 0);
      step();

      // Full queue, ignored allocation, wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         chk("t3_tag_seq", int'(bus.alloc_tag), i);
         alloc(i + 1, 7'h10 + i, 0);
      end
      chk("t3_count_full", int'(bus.count), 4);
      chk("t3_ready_full", int'(bus.alloc_ready), 0);
      chk("t3_tag_full", int'(bus.alloc_tag), 0);
      alloc(9, 9, 1);
      chk("t3_count_ignored", int'(bus.count), 4);
      chk("t3_tag_ignored", int'(bus.alloc_tag), 0);
      expect_train(1, 7'h10, 0, 0, 2);
      resolve(0, 0);
      chk("t3_ready_pre_retire", int'(bus.alloc_ready), 0);
      step();
      chk("t3_ready_post_retire", int'(bus.alloc_ready), 1);
      chk("t3_count_post_retire", int'(bus.count), 3);
      chk("t3_tag_wrap", int'(bus.alloc_tag), 0);
      alloc(5, 5, 0);
      chk("t3_count_refill", int'(bus.count), 4);
      chk("t3_tag_refill", int'(bus.alloc_tag), 1);

      // Mispredict at head squashes younger entries
      do_reset();
      alloc(30, 7'h30, 1);
      alloc(31, 7'h31, 1);
      alloc(32, 7'h32, 1);
      expect_train(30, 7'h30, 0, 1, 2);
      resolve(0, 0);
      resolve(1, 0);
      resolve(2, 0);
      step();
      step();
      chk("t4_count_squash", int'(bus.count), 0);
      chk("t4_ready_squash", int'(bus.alloc_ready), 1);
      chk("t4_tag_squash", int'(bus.alloc_tag), 1);

      // Flush on the retire edge drops the pulse; stale resolve ignored
      do_reset();
      alloc(40, 7'h40, 0);
      alloc(41, 7'h41, 0);
      alloc(42, 7'h42, 0);
      bus.resolve_valid = 1'b1;
      bus.resolve_tag   = 2'd0;
      bus.resolve_taken = 1'b0;
      step();
      bus.resolve_valid = 1'b0;
      bus.flush         = 1'b1;
      step();
      bus.flush         = 1'b0;
      chk("t5_count_flush", int'(bus.count), 0);
      chk("t5_tag_flush", int'(bus.alloc_tag), 0);
      chk("t5_train_valid_flush", int'(bus.train_valid), 0);
      resolve(1, 1);
      step();
      step();
      chk("t5_count_stale", int'(bus.count), 0);

      // Reset mid-drain
      do_reset();
      alloc(50, 7'h50, 0);
      alloc(51, 7'h51, 0);
      alloc(52, 7'h52, 0);
      expect_train(50, 7'h50, 0, 0, 2);
      resolve(0, 0);
      expect_train(51, 7'h51, 0, 0, 2);
      resolve(1, 0);
      resolve(2, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_vals("rst_mid");
      step();
      step();

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
